// File: rtl/req_rr_arbiter.sv
// req_rr_arbiter: round-robin arbiter that shares one downstream
// request/response channel between NUM_REQ upstream requesters.
// One transaction is outstanding at a time. A watchdog turns a downstream
// completion that never arrives into an error response to the requester.
// Every output comes straight from a register.
module req_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        resetn,
  // upstream requesters
  input  logic [NUM_REQ-1:0]          s_req_valid,
  output logic [NUM_REQ-1:0]          s_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   s_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   s_req_wdata,
  input  logic [NUM_REQ-1:0]          s_req_write,
  output logic [DATA_W-1:0]           s_resp_rdata,
  output logic [NUM_REQ-1:0]          s_resp_done,
  output logic [NUM_REQ-1:0]          s_resp_err,
  // downstream channel
  output logic                        m_req_valid,
  input  logic                        m_req_ready,
  output logic [ADDR_W-1:0]           m_req_addr,
  output logic [DATA_W-1:0]           m_req_wdata,
  output logic                        m_req_write,
  input  logic [DATA_W-1:0]           m_resp_rdata,
  input  logic                        m_resp_done
);

  // Grant index width; one extra bit is kept for the wrap-around sum.
  localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW1 = GW + 1;
  localparam logic [GW1-1:0] NUM_REQ_W = GW1'(NUM_REQ);
  localparam logic [GW-1:0]  LAST_IDX  = GW'(NUM_REQ - 1);

  // Watchdog: TIMEOUT == 0 disables it; otherwise it fires when the
  // counter (0 on the first WAIT cycle) reaches TIMEOUT-1.
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t               r_state;
  logic [GW-1:0]        r_grant;
  logic [GW-1:0]        r_last_grant;
  logic [15:0]          r_cnt;
  logic [NUM_REQ-1:0]   r_s_req_ready;
  logic [NUM_REQ-1:0]   r_s_resp_done;
  logic [NUM_REQ-1:0]   r_s_resp_err;
  logic [DATA_W-1:0]    r_s_resp_rdata;
  logic                 r_m_req_valid;
  logic [ADDR_W-1:0]    r_m_req_addr;
  logic [DATA_W-1:0]    r_m_req_wdata;
  logic                 r_m_req_write;

  // ---------------------------------------------------------------------
  // Next-state values and helpers
  // ---------------------------------------------------------------------
  state_t               w_state_nxt;
  logic [GW-1:0]        w_grant_nxt;
  logic [GW-1:0]        w_last_grant_nxt;
  logic [15:0]          w_cnt_nxt;
  logic [NUM_REQ-1:0]   w_s_req_ready_nxt;
  logic [NUM_REQ-1:0]   w_s_resp_done_nxt;
  logic [NUM_REQ-1:0]   w_s_resp_err_nxt;
  logic [DATA_W-1:0]    w_s_resp_rdata_nxt;
  logic                 w_m_req_valid_nxt;
  logic [ADDR_W-1:0]    w_m_req_addr_nxt;
  logic [DATA_W-1:0]    w_m_req_wdata_nxt;
  logic                 w_m_req_write_nxt;

  logic [ADDR_W-1:0]    w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]    w_wdata_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [NUM_REQ-1:0]   w_arb_oh;
  logic                 w_arb_found;
  logic [GW-1:0]        w_arb_idx;
  logic [GW1-1:0]       w_cand_sum;
  logic [GW-1:0]        w_cand;
  logic                 w_timeout;

  // Per-requester payload slices and one-hot decodes of the grant indices.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_addr_arr[gi]  = s_req_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = s_req_wdata[gi*DATA_W +: DATA_W];
    assign w_grant_oh[gi]  = (r_grant == GW'(gi));
    assign w_arb_oh[gi]    = w_arb_found && (w_arb_idx == GW'(gi));
  end

  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    w_cand_sum  = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand_sum = {1'b0, r_last_grant} + GW1'(k);
      if (w_cand_sum >= NUM_REQ_W) begin
        w_cand_sum = w_cand_sum - NUM_REQ_W;
      end
      w_cand = w_cand_sum[GW-1:0];
      if (!w_arb_found && s_req_valid[w_cand]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = w_cand;
      end
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    w_state_nxt        = r_state;
    w_grant_nxt        = r_grant;
    w_last_grant_nxt   = r_last_grant;
    w_cnt_nxt          = r_cnt;
    w_s_req_ready_nxt  = '0;
    w_s_resp_done_nxt  = '0;
    w_s_resp_err_nxt   = '0;
    w_s_resp_rdata_nxt = r_s_resp_rdata;
    w_m_req_valid_nxt  = r_m_req_valid;
    w_m_req_addr_nxt   = r_m_req_addr;
    w_m_req_wdata_nxt  = r_m_req_wdata;
    w_m_req_write_nxt  = r_m_req_write;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_found) begin
          w_grant_nxt       = w_arb_idx;
          w_s_req_ready_nxt = w_arb_oh;
          w_state_nxt       = ST_ACCEPT;
        end
      end

      ST_ACCEPT: begin
        // Ready is high this cycle; a requester that withdrew forfeits the
        // slot without moving the priority pointer.
        if (s_req_valid[r_grant]) begin
          w_m_req_addr_nxt  = w_addr_arr[r_grant];
          w_m_req_wdata_nxt = w_wdata_arr[r_grant];
          w_m_req_write_nxt = s_req_write[r_grant];
          w_m_req_valid_nxt = 1'b1;
          w_state_nxt       = ST_ISSUE;
        end else begin
          w_state_nxt       = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (m_req_ready) begin
          w_m_req_valid_nxt = 1'b0;
          w_cnt_nxt         = '0;
          w_state_nxt       = ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_cnt_nxt = r_cnt + 16'd1;
        // A real completion takes precedence over a simultaneous timeout.
        if (m_resp_done) begin
          w_s_resp_rdata_nxt = m_resp_rdata;
          w_s_resp_done_nxt  = w_grant_oh;
          w_state_nxt        = ST_RESP;
        end else if (w_timeout) begin
          w_s_resp_rdata_nxt = '0;
          w_s_resp_done_nxt  = w_grant_oh;
          w_s_resp_err_nxt   = w_grant_oh;
          w_state_nxt        = ST_RESP;
        end
      end

      ST_RESP: begin
        w_last_grant_nxt = r_grant;
        w_state_nxt      = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_grant        <= '0;
      r_last_grant   <= LAST_IDX;
      r_cnt          <= '0;
      r_s_req_ready  <= '0;
      r_s_resp_done  <= '0;
      r_s_resp_err   <= '0;
      r_s_resp_rdata <= '0;
      r_m_req_valid  <= 1'b0;
      r_m_req_addr   <= '0;
      r_m_req_wdata  <= '0;
      r_m_req_write  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_grant        <= w_grant_nxt;
      r_last_grant   <= w_last_grant_nxt;
      r_cnt          <= w_cnt_nxt;
      r_s_req_ready  <= w_s_req_ready_nxt;
      r_s_resp_done  <= w_s_resp_done_nxt;
      r_s_resp_err   <= w_s_resp_err_nxt;
      r_s_resp_rdata <= w_s_resp_rdata_nxt;
      r_m_req_valid  <= w_m_req_valid_nxt;
      r_m_req_addr   <= w_m_req_addr_nxt;
      r_m_req_wdata  <= w_m_req_wdata_nxt;
      r_m_req_write  <= w_m_req_write_nxt;
    end
  end

  assign s_req_ready  = r_s_req_ready;
  assign s_resp_done  = r_s_resp_done;
  assign s_resp_err   = r_s_resp_err;
  assign s_resp_rdata = r_s_resp_rdata;
  assign m_req_valid  = r_m_req_valid;
  assign m_req_addr   = r_m_req_addr;
  assign m_req_wdata  = r_m_req_wdata;
  assign m_req_write  = r_m_req_write;

endmodule
